// File: rtl/grid_angle_pkg.sv
// Shared types and constants for the grid-angle emulator: FSM states,
// frequency-select encodings, prescaler presets and channel offset helper.
package grid_angle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLEW = 2'd2
  } state_e;

  localparam logic [1:0] FSEL_50   = 2'd0;
  localparam logic [1:0] FSEL_60   = 2'd1;
  localparam logic [1:0] FSEL_CFG  = 2'd2;
  localparam logic [1:0] FSEL_HOLD = 2'd3;

  localparam int unsigned PRESC_50_DEF = 489;
  localparam int unsigned PRESC_60_DEF = 408;

  // Spacing between adjacent output channels: one turn split evenly, rounded down.
  function automatic int unsigned chan_ofs(input int unsigned theta_w, input int unsigned n_ch);
    return (32'd1 << theta_w) / n_ch;
  endfunction

endpackage

// File: rtl/grid_angle_presc.sv
// Step prescaler: selects the period limit from freq_sel and counts up to it,
// emitting a one-cycle step strobe when the count reaches or passes the limit.
module grid_angle_presc
  import grid_angle_pkg::*;
#(
  parameter int unsigned PRESC_W  = 12,
  parameter int unsigned PRESC_50 = PRESC_50_DEF,
  parameter int unsigned PRESC_60 = PRESC_60_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               freeze,
  input  logic [1:0]         freq_sel,
  input  logic [PRESC_W-1:0] presc_cfg,
  output logic               step
);

  logic [PRESC_W-1:0] count_q, count_d;
  logic [PRESC_W-1:0] limit;
  logic               hold;

  always_comb begin
    limit = presc_cfg;
    hold  = 1'b0;
    case (freq_sel)
      FSEL_50:  limit = PRESC_W'(PRESC_50);
      FSEL_60:  limit = PRESC_W'(PRESC_60);
      FSEL_CFG: limit = presc_cfg;
      default:  hold  = 1'b1;
    endcase
  end

  // ">=" so that a limit lowered below the running count steps immediately.
  always_comb begin
    step    = 1'b0;
    count_d = count_q + PRESC_W'(1);
    if (clear || freeze || hold) begin
      count_d = '0;
    end else if (count_q >= limit) begin
      step    = 1'b1;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/grid_angle_gen.sv
// Grid-angle emulator: a stepping electrical angle with jump/slew resync,
// fanned out to N_CH phase-shifted channels.
module grid_angle_gen
  import grid_angle_pkg::*;
#(
  parameter int unsigned THETA_W  = 10,
  parameter int unsigned PRESC_W  = 12,
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PRESC_50 = PRESC_50_DEF,
  parameter int unsigned PRESC_60 = PRESC_60_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [THETA_W-1:0]        theta_in,
  input  logic                      theta_vld,
  input  logic                      mode_slew,
  input  logic [1:0]                freq_sel,
  input  logic [PRESC_W-1:0]        presc_cfg,
  input  logic                      dir,
  output logic [N_CH*THETA_W-1:0]   theta_out,
  output logic                      wrap_pulse,
  output logic                      busy,
  output logic [1:0]                state_o
);

  localparam int unsigned OFS = chan_ofs(THETA_W, N_CH);
  localparam logic [THETA_W-1:0] HALF = {1'b1, {(THETA_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [THETA_W-1:0] theta_q, theta_d;
  logic [THETA_W-1:0] target_q, target_d;
  logic [THETA_W-1:0] theta_step, slew_dist;
  logic               wrap_q, wrap_d;
  logic               step;
  logic               presc_clear, presc_freeze;

  assign presc_clear  = !en || (state_q == ST_IDLE) || theta_vld;
  assign presc_freeze = (state_q == ST_SLEW);

  grid_angle_presc #(
    .PRESC_W  (PRESC_W),
    .PRESC_50 (PRESC_50),
    .PRESC_60 (PRESC_60)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .clear     (presc_clear),
    .freeze    (presc_freeze),
    .freq_sel  (freq_sel),
    .presc_cfg (presc_cfg),
    .step      (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      theta_q  <= '0;
      target_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      theta_q  <= theta_d;
      target_q <= target_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    theta_d    = theta_q;
    target_d   = target_q;
    wrap_d     = 1'b0;
    slew_dist  = '0;
    theta_step = dir ? theta_q + THETA_W'(1) : theta_q - THETA_W'(1);
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (theta_vld) begin
            if (!mode_slew) begin
              theta_d = theta_in;
            end else if (theta_in != theta_q) begin
              target_d = theta_in;
              state_d  = ST_SLEW;
            end
          end else if (step) begin
            theta_d = theta_step;
            wrap_d  = dir ? (theta_q == '1) : (theta_q == '0);
          end
        end
        ST_SLEW: begin
          // A fresh sample retargets immediately; this cycle's move heads to it.
          if (theta_vld) target_d = theta_in;
          slew_dist = target_d - theta_q;
          if (slew_dist != '0)
            theta_d = (slew_dist <= HALF) ? theta_q + THETA_W'(1) : theta_q - THETA_W'(1);
          if (theta_d == target_d) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == ST_SLEW);
    state_o    = state_q;
    wrap_pulse = wrap_q;
    theta_out  = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      theta_out[k*THETA_W +: THETA_W] = theta_q + THETA_W'(k * OFS);
  end

endmodule

// File: tb/tb_grid_angle_gen.sv
// Self-checking bench for grid_angle_gen: vector table, directed corner
// sequences and randomized stimulus against an arithmetic reference model.
module tb_grid_angle_gen;

  localparam int W   = 10;
  localparam int N   = 3;
  localparam int M   = 1024;
  localparam int OFS = 341;

  logic          clk = 1'b0;
  logic          rst, en, theta_vld, mode_slew, dir;
  logic [W-1:0]  theta_in;
  logic [1:0]    freq_sel;
  logic [11:0]   presc_cfg;
  logic [N*W-1:0] theta_out;
  logic          wrap_pulse, busy;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  grid_angle_gen #(
    .THETA_W  (W),
    .PRESC_W  (12),
    .N_CH     (N),
    .PRESC_50 (489),
    .PRESC_60 (408)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .theta_in   (theta_in),
    .theta_vld  (theta_vld),
    .mode_slew  (mode_slew),
    .freq_sel   (freq_sel),
    .presc_cfg  (presc_cfg),
    .dir        (dir),
    .theta_out  (theta_out),
    .wrap_pulse (wrap_pulse),
    .busy       (busy),
    .state_o    (state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 slew
  int m_state = 0, m_theta = 0, m_count = 0, m_target = 0, m_wrap = 0;

  typedef struct {
    int rst, en, vld, tin, ms, fs, cfg, dir;
    int ch0, wrap, busy, st;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch(input int k);
    return int'(theta_out[k*W +: W]);
  endfunction

  task automatic model_step();
    int lim, d;
    if (rst) begin
      m_state = 0; m_theta = 0; m_count = 0; m_target = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (!en) begin
        m_state = 0; m_count = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_count = 0;
      end else if (m_state == 1) begin
        if (theta_vld) begin
          m_count = 0;
          if (!mode_slew) m_theta = int'(theta_in);
          else if (int'(theta_in) != m_theta) begin
            m_target = int'(theta_in);
            m_state  = 2;
          end
        end else begin
          case (freq_sel)
            2'd0:    lim = 489;
            2'd1:    lim = 408;
            2'd2:    lim = int'(presc_cfg);
            default: lim = -1;
          endcase
          if (lim < 0) m_count = 0;
          else if (m_count >= lim) begin
            m_count = 0;
            if (dir) begin
              m_wrap  = (m_theta == M-1) ? 1 : 0;
              m_theta = (m_theta + 1) % M;
            end else begin
              m_wrap  = (m_theta == 0) ? 1 : 0;
              m_theta = (m_theta + M - 1) % M;
            end
          end else m_count++;
        end
      end else begin
        if (theta_vld) m_target = int'(theta_in);
        d = (m_target - m_theta + M) % M;
        if (d != 0) m_theta = (d <= M/2) ? (m_theta + 1) % M : (m_theta + M - 1) % M;
        if (m_theta == m_target) m_state = 1;
        m_count = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < N; k++)
      check($sformatf("model_ch%0d", k), ch(k), (m_theta + k*OFS) % M);
    check("model_wrap", int'(wrap_pulse), m_wrap);
    check("model_busy", int'(busy), (m_state == 2) ? 1 : 0);
    check("model_state", int'(state_o), m_state);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic jump(input int t);
    theta_vld = 1'b1; mode_slew = 1'b0; theta_in = W'(t);
    tick();
    theta_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; theta_vld = 1'b0; mode_slew = 1'b0; dir = 1'b1;
    theta_in = '0; freq_sel = 2'd0; presc_cfg = '0;

    //            rst en vld tin ms fs cfg dir | ch0  wrap busy st
    vecs[0]  = '{1, 0, 0, 0,   0, 0, 0, 0,    0,    0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0,   0, 2, 0, 0,    0,    0, 0, 1};
    vecs[2]  = '{0, 1, 0, 0,   0, 2, 0, 0,    1023, 1, 0, 1};
    vecs[3]  = '{0, 1, 0, 0,   0, 2, 0, 0,    1022, 0, 0, 1};
    vecs[4]  = '{0, 1, 1, 500, 0, 2, 0, 0,    500,  0, 0, 1};
    vecs[5]  = '{0, 1, 0, 0,   0, 3, 0, 0,    500,  0, 0, 1};
    vecs[6]  = '{0, 1, 1, 502, 1, 3, 0, 0,    500,  0, 1, 2};
    vecs[7]  = '{0, 1, 0, 0,   0, 3, 0, 0,    501,  0, 1, 2};
    vecs[8]  = '{0, 1, 0, 0,   0, 3, 0, 0,    502,  0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0,   0, 3, 0, 0,    502,  0, 0, 0};
    vecs[10] = '{1, 0, 0, 0,   0, 3, 0, 0,    0,    0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst = 1'(vecs[i].rst); en = 1'(vecs[i].en); theta_vld = 1'(vecs[i].vld);
      theta_in = W'(vecs[i].tin); mode_slew = 1'(vecs[i].ms);
      freq_sel = 2'(vecs[i].fs); presc_cfg = 12'(vecs[i].cfg); dir = 1'(vecs[i].dir);
      tick();
      check($sformatf("vec%0d_ch0", i), ch(0), vecs[i].ch0);
      check($sformatf("vec%0d_wrap", i), int'(wrap_pulse), vecs[i].wrap);
      check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].busy);
      check($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
    end
    check("reset_ch1", ch(1), 341);
    check("reset_ch2", ch(2), 682);

    // 50 Hz preset: step every 490 cycles once running
    rst = 1'b0; theta_vld = 1'b0; en = 1'b1; freq_sel = 2'd0; dir = 1'b1;
    tick();
    ticks(489);
    check("p50_before_step", ch(0), 0);
    tick();
    check("p50_first_step", ch(0), 1);
    ticks(489);
    check("p50_before_second", ch(0), 1);
    tick();
    check("p50_second_step", ch(0), 2);

    // Jump restarts the prescaler
    jump(100);
    jump(500);
    check("jump_ch0", ch(0), 500);
    check("jump_ch1", ch(1), 841);
    ticks(489);
    check("jump_hold", ch(0), 500);
    tick();
    check("jump_next_step", ch(0), 501);

    // Slew across the wrap along the short path, no wrap pulse
    jump(1020);
    theta_vld = 1'b1; mode_slew = 1'b1; theta_in = W'(4);
    tick();
    theta_vld = 1'b0;
    check("slew_entry_busy", int'(busy), 1);
    check("slew_entry_ch0", ch(0), 1020);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("slew_ch0_%0d", i), ch(0), (1020 + i) % M);
      check($sformatf("slew_wrap_%0d", i), int'(wrap_pulse), 0);
    end
    check("slew_done_state", int'(state_o), 1);
    check("slew_done_busy", int'(busy), 0);

    // Half-turn tie increments
    jump(0);
    theta_vld = 1'b1; mode_slew = 1'b1; theta_in = W'(512);
    tick();
    theta_vld = 1'b0;
    tick();
    check("tie_increments", ch(0), 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();

    // en=0 abandons a slew and holds theta
    jump(10);
    theta_vld = 1'b1; mode_slew = 1'b1; theta_in = W'(50);
    tick();
    theta_vld = 1'b0; en = 1'b0;
    tick();
    check("abort_state", int'(state_o), 0);
    check("abort_ch0", ch(0), 10);
    check("abort_busy", int'(busy), 0);
    tick();
    check("abort_hold", ch(0), 10);
    en = 1'b1;
    tick();

    // Lowered limit below the running count steps on the next cycle
    freq_sel = 2'd0;
    jump(200);
    ticks(300);
    check("lim_mid_count", ch(0), 200);
    freq_sel = 2'd1;
    ticks(5);
    check("lim_p60_no_step", ch(0), 200);
    freq_sel = 2'd2; presc_cfg = 12'd100;
    tick();
    check("lim_cfg_step", ch(0), 201);
    tick();
    check("lim_cfg_restart", ch(0), 201);

    // Reset during RUN
    rst = 1'b1;
    tick();
    check("rst_ch0", ch(0), 0);
    check("rst_ch1", ch(1), 341);
    check("rst_ch2", ch(2), 682);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_o), 0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 59) != 0);
      theta_vld = ($urandom_range(0, 19) == 0);
      mode_slew = 1'($urandom_range(0, 1));
      theta_in  = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'(m_theta + $urandom_range(0, 8) - 4);
      freq_sel  = 2'($urandom_range(0, 3));
      presc_cfg = 12'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
